// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the global branch history update path.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [11:0] lc3b_ghr;
    typedef logic [11:0] lc3b_global_bht_pattern_index;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } lc3b_bht_counter;

    typedef struct packed {
        lc3b_word pc;
        logic     taken;
        lc3b_ghr  ghr;
    } bht_update_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } bht_upd_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic lc3b_bht_counter bht_counter_next(input lc3b_bht_counter cur,
                                                         input logic taken);
        lc3b_bht_counter nxt;
        nxt = cur;
        case (cur)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/global_bht_update_fifo.sv
// Pending-update FIFO; the extra pointer bit distinguishes full from empty.
module global_bht_update_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  bht_update_t push_data,
    input  logic        pop,
    output bht_update_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;
    bht_update_t mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/global_bht_update_unit.sv
// Global BHT write-side controller: queues resolved branches, owns the GHR,
// and read-modify-writes one 2-bit counter per report.
module global_bht_update_unit
    import lc3b_types::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  lc3b_word                     upd_pc,
    input  logic                         upd_taken,
    input  lc3b_ghr                      upd_ghr,
    output lc3b_ghr                      ghr,
    output logic                         busy,
    output logic                         arr_write,
    output lc3b_global_bht_pattern_index arr_index_in,
    output logic [WIDTH-1:0]             arr_datain,
    input  logic [WIDTH-1:0]             arr_dataout
);

    localparam int SLOT_W = $clog2(WIDTH/2);

    bht_upd_state_e               state_q;
    bht_upd_state_e               state_d;
    logic                         accept;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    bht_update_t                  push_data;
    bht_update_t                  head;
    lc3b_global_bht_pattern_index head_row;
    logic [SLOT_W-1:0]            head_slot;
    logic [3:0]                   unused_pc_bits;

    lc3b_ghr                      ghr_q;
    lc3b_global_bht_pattern_index row_idx_q;
    logic [SLOT_W-1:0]            slot_q;
    logic                         taken_q;
    logic [WIDTH-1:0]             row_q;

    lc3b_bht_counter              cur_ctr;
    lc3b_bht_counter              new_ctr;
    logic [WIDTH-1:0]             row_upd;

    assign accept    = upd_valid && upd_ready;
    assign upd_ready = !fifo_full;
    assign push_data = '{pc: upd_pc, taken: upd_taken, ghr: upd_ghr};

    global_bht_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_row       = head.pc[12:1] ^ head.ghr;
    assign head_slot      = head.pc[SLOT_W:1];
    assign unused_pc_bits = {head.pc[15:13], head.pc[0]};

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = READ;
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ghr_q     <= '0;
            row_idx_q <= '0;
            slot_q    <= '0;
            taken_q   <= 1'b0;
            row_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) ghr_q <= {ghr_q[10:0], upd_taken};
            if (pop) begin
                row_idx_q <= head_row;
                slot_q    <= head_slot;
                taken_q   <= head.taken;
            end
            if (state_q == READ) row_q <= arr_dataout;
        end
    end

    // Only the addressed counter changes; the rest of the row is written back as read.
    always_comb begin
        cur_ctr = lc3b_bht_counter'(row_q[{slot_q, 1'b0} +: 2]);
        new_ctr = bht_counter_next(cur_ctr, taken_q);
        row_upd = row_q;
        row_upd[{slot_q, 1'b0} +: 2] = new_ctr;
    end

    assign arr_write    = (state_q == WRITE);
    assign arr_index_in = row_idx_q;
    assign arr_datain   = arr_write ? row_upd : row_q;
    assign busy         = !fifo_empty || (state_q != IDLE);
    assign ghr          = ghr_q;

endmodule

// File: doc/global_bht_update_unit.md
# global_bht_update_unit

Write-side controller for the global branch history pattern array. Accepts resolved-branch reports from the pipeline through a valid/ready handshake and buffers them in a small FIFO. For each report it performs a two-phase read-modify-write of one 2-bit saturating counter in a 128-bit pattern row. It also owns the architectural global history register (GHR) that the fetch-side predictor hashes with the PC.

## Interface
- WIDTH, 128, pattern row width; holds WIDTH/2 counters; SLOT_W = log2(WIDTH/2) = 6
- DEPTH, 4, pending-update FIFO entries (power of two)
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  resolved-branch report present
- upd_ready  out  1  unit can accept a report (FIFO not full)
- upd_pc  in  16  branch PC (lc3b_word)
- upd_taken  in  1  resolved direction
- upd_ghr  in  12  GHR value used when the branch was predicted
- ghr  out  12  architectural GHR, to the fetch-side hash
- busy  out  1  FIFO non-empty or FSM not IDLE
- arr_write  out  1  array write enable; the array commits on negedge clk
- arr_index_in  out  12  array update-side row index (lc3b_global_bht_pattern_index)
- arr_datain  out  WIDTH  full row to write
- arr_dataout  in  WIDTH  combinational read of row arr_index_in

## Operation
- Handshake: a report is accepted on a posedge with upd_valid && upd_ready. upd_ready = !fifo_full. A push and pop in the same cycle are legal when the FIFO is not full.
- GHR: on acceptance, ghr <= {ghr[10:0], upd_taken}. The FIFO stores upd_ghr, not ghr.
- Hash: row = upd_pc[12:1] ^ upd_ghr. slot = upd_pc[SLOT_W:1]. Counter s occupies row bits [2s+1:2s].
- Counter: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Taken: increment, saturating at 11.
  - Not-taken: decrement, saturating at 00.
- FSM, states IDLE, READ, WRITE:
  - IDLE: if the FIFO is non-empty, pop the head into the working registers (row, slot, taken) and go to READ.
  - READ: drive arr_index_in = row. At the posedge, capture arr_dataout into row_q and go to WRITE.
  - WRITE: arr_write = 1. arr_datain = row_q with only the addressed slot replaced by the updated counter. Next state:
    - FIFO non-empty: pop and go to READ.
    - FIFO empty: go to IDLE.
- arr_index_in holds the working row in all states. arr_datain = row_q outside WRITE. arr_write is 1 only in WRITE and is decoded from state with no glitches.
- Updates commit in acceptance order. A back-to-back update to the same row re-reads the array, so it sees the previous write; no bypass is needed.

## Timing
- Reset values: state IDLE, FIFO empty, ghr 0, upd_ready 1, busy 0, arr_write 0, arr_index_in 0, arr_datain 0, working registers 0.
- Latency: a report accepted at the edge ending cycle 0 gives IDLE in cycle 1, READ in cycle 2, and arr_write = 1 in cycle 3. The array commits at the negedge of cycle 3.
- Sustained throughput: one update per 2 cycles (READ/WRITE alternating).
- FIFO full: upd_ready = 0. upd_valid is ignored and ghr does not shift.
- Reset asserted mid-operation: all state returns to reset values immediately, and arr_write drops combinationally. In-flight and queued updates are discarded. The array itself is not cleared.
- Acceptance in the same cycle as a WRITE is legal: the push and pop use independent FIFO pointers.

## Structure
- Add to lc3b_types:
  - lc3b_ghr: 12-bit GHR type.
  - lc3b_bht_counter: 2-bit enum.
  - The existing lc3b_global_bht_pattern_index type (12 bits) is used for arr_index_in.
- Sub-module global_bht_update_fifo: parameterised DEPTH, entry {pc, taken, ghr}, push/pop with full/empty flags, async active-low reset.
- The FSM, hash and counter datapath live in the top module.

## Test plan
- Reset: hold reset_n = 0.
  - Required: upd_ready = 1, busy = 0, ghr = 0x000, arr_write = 0.
- Single update: upd_pc = 0x0004, upd_ghr = 0x000, taken = 1, array row zeroed.
  - Required: arr_write in cycle 3 with arr_index_in = 0x002 and arr_datain = 0x…0010 (bits [5:4] = 01, all other bits 0).
  - Required: ghr = 0x001 after the accept edge.
- Saturation: four taken then four not-taken reports with the same pc/ghr.
  - Required: successive slot values 01, 10, 11, 11, 10, 01, 00, 00.
- Row preservation: preload the row with 0xAAAA…AAAA, then send a taken report to slot 63.
  - Required: only bits [127:126] change, 10 -> 11.
- Backpressure: upd_valid held high for 8 cycles with distinct PCs.
  - Required: upd_ready falls while the FIFO holds 4 entries.
  - Required: the number of writes equals the number of accepted reports, issued in acceptance order.
  - Required: ghr shifts only on accepted reports.
- Mid-operation reset: assert reset_n = 0 during WRITE with 2 reports queued.
  - Required: arr_write drops the same cycle and no further writes occur after release.
  - Required: upd_ready = 1 and ghr = 0.
